// File: rtl/aes_uart_block_packer_pkg.sv
// Shared definitions for the UART <-> AES block packer and unpacker.
//   AES_BLOCK_BYTES / AES_BLOCK_W : size of one AES block in bytes / bits
//   DEFAULT_TIMEOUT_CYC           : idle cycles before a partial block is dropped
//   ing_state_t / eg_state_t      : ingress and egress FSM state encodings
package aes_uart_block_packer_pkg;

   localparam int AES_BLOCK_BYTES     = 16;
   localparam int AES_BLOCK_W         = 8 * AES_BLOCK_BYTES;
   localparam int DEFAULT_TIMEOUT_CYC = 50000;   // 1 ms at 50 MHz

   typedef enum logic {
      ING_COLLECT = 1'b0,
      ING_HOLD    = 1'b1
   } ing_state_t;

   typedef enum logic {
      EG_IDLE = 1'b0,
      EG_SEND = 1'b1
   } eg_state_t;

endpackage

// File: rtl/aes_uart_block_packer_unpacker.sv
// Egress half of the packer: accepts one AES result block and serialises it
// to the UART transmitter, most significant byte first.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   blk_out_data/valid/ready   128-bit result block from the AES core
//   tx_data/valid/ready        byte stream to the UART TX
module aes_uart_block_unpacker
   import aes_uart_block_packer_pkg::*;
#(
   parameter int BLK_W = AES_BLOCK_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BLK_W-1:0] blk_out_data,
   input  logic             blk_out_valid,
   output logic             blk_out_ready,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready
);

   localparam int                 IDX_W    = $clog2(BLK_W / 8);
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(BLK_W / 8 - 1);

   eg_state_t        st_q,  st_nxt;
   logic [BLK_W-1:0] sr_q,  sr_nxt;
   logic [IDX_W-1:0] idx_q, idx_nxt;
   logic             rdy_q;

   always_comb begin
      st_nxt  = st_q;
      sr_nxt  = sr_q;
      idx_nxt = idx_q;
      case (st_q)
         EG_IDLE: begin
            if (blk_out_valid && rdy_q) begin
               sr_nxt  = blk_out_data;
               idx_nxt = '0;
               st_nxt  = EG_SEND;
            end
         end
         EG_SEND: begin
            if (tx_ready) begin
               sr_nxt  = {sr_q[BLK_W-9:0], 8'h00};
               idx_nxt = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  st_nxt = EG_IDLE;
               end
            end
         end
         default: st_nxt = EG_IDLE;
      endcase
   end

   // ready is registered so it stays low during reset and rises on the first
   // edge after release, or on the edge that completes the last byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= EG_IDLE;
         sr_q  <= '0;
         idx_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         st_q  <= st_nxt;
         sr_q  <= sr_nxt;
         idx_q <= idx_nxt;
         rdy_q <= (st_nxt == EG_IDLE);
      end
   end

   assign blk_out_ready = rdy_q;
   assign tx_valid      = (st_q == EG_SEND);
   assign tx_data       = sr_q[BLK_W-1 -: 8];

endmodule

// File: rtl/aes_uart_block_packer.sv
// Adapts the UART byte stream to the 128-bit AES core.
// Ingress collects BLOCK_BYTES received bytes (first byte in the top byte
// lane) into one block and offers it over valid/ready; a partial block that
// sits idle for TIMEOUT_CYC cycles is discarded. Egress is delegated to
// aes_uart_block_unpacker. Both directions run independently.
// Ports:
//   clk_50m, rst_n              clock, asynchronous active-low reset
//   rx_data, rx_valid           byte strobe from UART RX (no backpressure)
//   blk_in_data/valid/ready     assembled block to the AES core
//   blk_out_data/valid/ready    result block from the AES core
//   tx_data/valid/ready         byte stream to UART TX
//   rx_overrun                  sticky: a byte arrived while a block was held
//   timeout_flush               one-cycle pulse: a partial block was dropped
module aes_uart_block_packer
   import aes_uart_block_packer_pkg::*;
#(
   parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
   parameter int TO_W        = 16
) (
   input  logic                     clk_50m,
   input  logic                     rst_n,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic [8*BLOCK_BYTES-1:0] blk_in_data,
   output logic                     blk_in_valid,
   input  logic                     blk_in_ready,
   input  logic [8*BLOCK_BYTES-1:0] blk_out_data,
   input  logic                     blk_out_valid,
   output logic                     blk_out_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     rx_overrun,
   output logic                     timeout_flush
);

   localparam int                CNT_W    = $clog2(BLOCK_BYTES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLOCK_BYTES - 1);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYC);

   // Timeout counter increment that holds at TO_MAX
   function automatic logic [TO_W-1:0] to_inc(input logic [TO_W-1:0] v);
      if (v >= TO_MAX) return v;
      return v + TO_W'(1);
   endfunction

   ing_state_t                        ing_q,   ing_nxt;
   logic [CNT_W-1:0]                  cnt_q,   cnt_nxt;
   logic [TO_W-1:0]                   to_q,    to_nxt;
   // byte lane BLOCK_BYTES-1 is bits [top:top-7], so byte k goes to lane LAST-k
   logic [BLOCK_BYTES-1:0][7:0]       data_q,  data_nxt;
   logic                              ovr_q,   ovr_nxt;
   logic                              flush_q, flush_nxt;

   always_comb begin
      ing_nxt   = ing_q;
      cnt_nxt   = cnt_q;
      to_nxt    = to_q;
      data_nxt  = data_q;
      ovr_nxt   = ovr_q;
      flush_nxt = 1'b0;
      case (ing_q)
         ING_COLLECT: begin
            if (rx_valid) begin
               // an arriving byte always beats a timer expiring in the same cycle
               data_nxt[CNT_LAST - cnt_q] = rx_data;
               cnt_nxt                    = cnt_q + CNT_W'(1);
               to_nxt                     = '0;
               if (cnt_q == CNT_LAST) begin
                  ing_nxt = ING_HOLD;
               end
            end else if (cnt_q != '0) begin
               to_nxt = to_inc(to_q);
               if (to_nxt == TO_MAX) begin
                  // drop the partial block; stale bytes stay in data_q
                  cnt_nxt   = '0;
                  to_nxt    = '0;
                  flush_nxt = 1'b1;
               end
            end
         end
         ING_HOLD: begin
            if (blk_in_ready) begin
               ing_nxt = ING_COLLECT;
               cnt_nxt = '0;
               if (rx_valid) begin
                  data_nxt[CNT_LAST] = rx_data;
                  cnt_nxt            = CNT_W'(1);
               end
            end else if (rx_valid) begin
               ovr_nxt = 1'b1;
            end
         end
         default: ing_nxt = ING_COLLECT;
      endcase
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         ing_q   <= ING_COLLECT;
         cnt_q   <= '0;
         to_q    <= '0;
         data_q  <= '0;
         ovr_q   <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         ing_q   <= ing_nxt;
         cnt_q   <= cnt_nxt;
         to_q    <= to_nxt;
         data_q  <= data_nxt;
         ovr_q   <= ovr_nxt;
         flush_q <= flush_nxt;
      end
   end

   assign blk_in_data   = data_q;
   assign blk_in_valid  = (ing_q == ING_HOLD);
   assign rx_overrun    = ovr_q;
   assign timeout_flush = flush_q;

   aes_uart_block_unpacker #(
      .BLK_W (8 * BLOCK_BYTES)
   ) u_unpacker (
      .clk           (clk_50m),
      .rst_n         (rst_n),
      .blk_out_data  (blk_out_data),
      .blk_out_valid (blk_out_valid),
      .blk_out_ready (blk_out_ready),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready)
   );

endmodule

// File: tb/tb_aes_uart_block_packer.sv
module tb_aes_uart_block_packer;

   localparam int TO = 1000;

   logic         clk_50m = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   rx_data = '0;
   logic         rx_valid = 1'b0;
   logic [127:0] blk_in_data;
   logic         blk_in_valid;
   logic         blk_in_ready = 1'b0;
   logic [127:0] blk_out_data = '0;
   logic         blk_out_valid = 1'b0;
   logic         blk_out_ready;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready = 1'b0;
   logic         rx_overrun;
   logic         timeout_flush;

   aes_uart_block_packer #(
      .BLOCK_BYTES (16),
      .TIMEOUT_CYC (TO),
      .TO_W        (16)
   ) dut (
      .clk_50m       (clk_50m),
      .rst_n         (rst_n),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .blk_in_data   (blk_in_data),
      .blk_in_valid  (blk_in_valid),
      .blk_in_ready  (blk_in_ready),
      .blk_out_data  (blk_out_data),
      .blk_out_valid (blk_out_valid),
      .blk_out_ready (blk_out_ready),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .rx_overrun    (rx_overrun),
      .timeout_flush (timeout_flush)
   );

   always #10 clk_50m = ~clk_50m;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [7:0]   m_bytes[$];   // bytes of the block being collected
   logic         m_hold;
   logic [127:0] m_blk;
   int           m_idle;
   logic         m_ovr;
   logic         m_flush;
   logic [7:0]   m_txq[$];     // result bytes still to be sent
   logic         m_ready;
   int           m_out_acc = 0;

   task automatic m_reset();
      m_bytes.delete();
      m_hold  = 1'b0;
      m_blk   = '0;
      m_idle  = 0;
      m_ovr   = 1'b0;
      m_flush = 1'b0;
      m_txq.delete();
      m_ready = 1'b0;
   endtask

   task automatic m_step();
      m_flush = 1'b0;
      if (m_hold) begin
         if (blk_in_ready) begin
            m_hold = 1'b0;
            if (rx_valid) m_bytes.push_back(rx_data);
         end else if (rx_valid) begin
            m_ovr = 1'b1;
         end
      end else if (rx_valid) begin
         m_bytes.push_back(rx_data);
         m_idle = 0;
         if (m_bytes.size() == 16) begin
            for (int i = 0; i < 16; i++) m_blk[127-8*i -: 8] = m_bytes[i];
            m_hold = 1'b1;
            m_bytes.delete();
         end
      end else if (m_bytes.size() != 0) begin
         m_idle++;
         if (m_idle >= TO) begin
            m_bytes.delete();
            m_idle  = 0;
            m_flush = 1'b1;
         end
      end
      if (m_txq.size() != 0) begin
         if (tx_ready) begin
            void'(m_txq.pop_front());
            if (m_txq.size() == 0) m_ready = 1'b1;
         end
      end else if (m_ready && blk_out_valid) begin
         for (int i = 0; i < 16; i++) m_txq.push_back(blk_out_data[127-8*i -: 8]);
         m_ready = 1'b0;
         m_out_acc++;
      end else begin
         m_ready = 1'b1;
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk_50m or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   // ---------------- per-cycle compare + observation logs ----------------
   logic [7:0]   act_tx[$];
   logic [127:0] act_blk[$];
   int           act_flush = 0;

   initial begin
      forever begin
         @(negedge clk_50m);
         #1;
         check("blk_in_valid", blk_in_valid, m_hold);
         if (m_hold) check("blk_in_data", blk_in_data, m_blk);
         check("rx_overrun", rx_overrun, m_ovr);
         check("timeout_flush", timeout_flush, m_flush);
         check("blk_out_ready", blk_out_ready, m_ready);
         check("tx_valid", tx_valid, m_txq.size() != 0);
         if (m_txq.size() != 0) check("tx_data", tx_data, m_txq[0]);
         if (!rst_n) begin
            check("rst_blk_in_data", blk_in_data, 128'h0);
            check("rst_tx_data", tx_data, 8'h00);
         end
         if (tx_valid && tx_ready) act_tx.push_back(tx_data);
         if (blk_in_valid && blk_in_ready) act_blk.push_back(blk_in_data);
         if (timeout_flush) act_flush++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk_50m);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk_50m);
      rx_valid = 1'b0;
      repeat (gap - 1) @(negedge clk_50m);
   endtask

   task automatic send_block(input logic [127:0] d);
      int  base = m_out_acc;
      bit  ok = 1'b0;
      @(negedge clk_50m);
      blk_out_valid = 1'b1;
      blk_out_data  = d;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk_50m);
         if (m_out_acc != base) begin
            ok = 1'b1;
            break;
         end
      end
      blk_out_valid = 1'b0;
      check("blk_out_accepted", ok, 1'b1);
   endtask

   task automatic pulse_in_ready();
      @(negedge clk_50m);
      blk_in_ready = 1'b1;
      @(negedge clk_50m);
      blk_in_ready = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [127:0] exp_blk;
      logic [127:0] exp_blk2;
      logic [7:0]   b;
      int           base;
      int           fbase;

      // reset state
      repeat (3) @(negedge clk_50m);
      #2;
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_blk_out_ready", blk_out_ready, 1'b0);
      check("rst_blk_in_valid", blk_in_valid, 1'b0);
      @(negedge clk_50m);
      rst_n = 1'b1;
      @(negedge clk_50m);
      #2;
      check("blk_out_ready_after_rst", blk_out_ready, 1'b1);

      // 1: bytes 00..0F spaced 400 cycles apart
      for (int i = 0; i < 16; i++) send_byte(8'(i), (i == 15) ? 1 : 400);
      #2;
      check("t1_valid", blk_in_valid, 1'b1);
      check("t1_data", blk_in_data, 128'h000102030405060708090A0B0C0D0E0F);
      repeat (10) @(negedge clk_50m);
      #2;
      check("t1_data_stable", blk_in_data, 128'h000102030405060708090A0B0C0D0E0F);
      pulse_in_ready();
      #2;
      check("t1_valid_drop", blk_in_valid, 1'b0);

      // 2: partial block of 5 bytes times out
      fbase = act_flush;
      for (int i = 0; i < 5; i++) send_byte(8'hAA, 2);
      repeat (TO + 5) @(negedge clk_50m);
      check("t2_flush_count", act_flush - fbase, 1);
      for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), (i == 15) ? 1 : 2);
      #2;
      check("t2_data", blk_in_data, 128'h101112131415161718191A1B1C1D1E1F);

      // 3: byte while the block is held is dropped
      send_byte(8'h55, 3);
      #2;
      check("t3_overrun", rx_overrun, 1'b1);
      check("t3_data_kept", blk_in_data, 128'h101112131415161718191A1B1C1D1E1F);
      pulse_in_ready();
      repeat (5) @(negedge clk_50m);
      #2;
      check("t3_overrun_sticky", rx_overrun, 1'b1);

      // 4: result block serialised with tx_ready toggling every 3 cycles
      base = act_tx.size();
      fork
         send_block(128'h00112233445566778899AABBCCDDEEFF);
         begin
            for (int c = 0; c < 400 && act_tx.size() < base + 16; c++) begin
               @(negedge clk_50m);
               if (c % 3 == 0) tx_ready = ~tx_ready;
            end
         end
      join
      tx_ready = 1'b0;
      check("t4_tx_count", act_tx.size() - base, 16);
      for (int i = 0; i < 16 && base + i < act_tx.size(); i++) begin
         b = {4'(i), 4'(i)};
         check("t4_tx_byte", act_tx[base+i], b);
      end
      repeat (2) @(negedge clk_50m);
      #2;
      check("t4_ready_back", blk_out_ready, 1'b1);

      // 5: reset in the middle of rx and tx
      for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i), 2);
      send_block({$urandom, $urandom, $urandom, $urandom});
      base = act_tx.size();
      tx_ready = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk_50m);
         #2;
         if (act_tx.size() >= base + 5) break;
      end
      check("t5_tx_before_rst", act_tx.size() - base, 5);
      @(negedge clk_50m);
      tx_ready = 1'b0;
      rst_n    = 1'b0;
      #2;
      check("t5_rst_tx_valid", tx_valid, 1'b0);
      check("t5_rst_blk_in_valid", blk_in_valid, 1'b0);
      check("t5_rst_overrun", rx_overrun, 1'b0);
      check("t5_rst_blk_out_ready", blk_out_ready, 1'b0);
      check("t5_rst_data", blk_in_data, 128'h0);
      repeat (3) @(negedge clk_50m);
      rst_n    = 1'b1;
      tx_ready = 1'b1;
      repeat (40) @(negedge clk_50m);
      check("t5_no_tx_after_rst", act_tx.size() - base, 5);
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         exp_blk[127-8*i -: 8] = b;
         send_byte(b, (i == 15) ? 1 : 2);
      end
      #2;
      check("t5_new_block", blk_in_data, exp_blk);
      pulse_in_ready();

      // 6: ready tied high, 17th byte coincides with acceptance
      blk_in_ready = 1'b1;
      base = act_blk.size();
      for (int i = 0; i < 32; i++) begin
         b = 8'($urandom);
         if (i < 16) exp_blk[127-8*i -: 8] = b;
         else exp_blk2[127-8*(i-16) -: 8] = b;
         send_byte(b, (i == 15) ? 1 : 2);
      end
      repeat (3) @(negedge clk_50m);
      check("t6_block_count", act_blk.size() - base, 2);
      if (act_blk.size() >= base + 2) begin
         check("t6_block0", act_blk[base], exp_blk);
         check("t6_block1", act_blk[base+1], exp_blk2);
      end
      check("t6_no_overrun", rx_overrun, 1'b0);
      blk_in_ready = 1'b0;

      // randomized traffic on both directions, with one long rx silence
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk_50m);
         if (blk_out_valid && m_out_acc != base) blk_out_valid = 1'b0;
         if (!blk_out_valid && ($urandom % 8 == 0)) begin
            blk_out_valid = 1'b1;
            blk_out_data  = {$urandom, $urandom, $urandom, $urandom};
            base          = m_out_acc;
         end
         rx_valid     = (c >= 1500 && c < 2700) ? 1'b0 : ($urandom % 3 == 0);
         rx_data      = 8'($urandom);
         blk_in_ready = ($urandom % 4 == 0);
         tx_ready     = $urandom % 2;
      end
      @(negedge clk_50m);
      rx_valid      = 1'b0;
      blk_out_valid = 1'b0;
      blk_in_ready  = 1'b1;
      tx_ready      = 1'b1;
      repeat (60) @(negedge clk_50m);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
